lane_seg_mac_requant: RTL and testbench
=======================================

Name: lane_seg_mac_requant

Overview:
- Downstream consumer of the 16s x 11ns -> 27-bit product stream in the lane-segmentation datapath.
- Accumulates one kernel window of signed products onto a bias, rounds, applies an arithmetic right shift, optionally applies ReLU, and saturates to a signed 16-bit activation.
- Sits between the multiplier array and the feature-map line buffer. Valid/ready handshake on both sides.

Parameters:
- PROD_W, 27, signed product width from the multiplier stage.
- ACC_W, 32, signed accumulator width (must be > PROD_W).
- OUT_W, 16, signed output activation width.
- MAX_TAPS, 64, maximum beats per window before forced termination.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_prod  in  PROD_W  signed product.
- in_last  in  1  marks final product of the window.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block accepts a beat.
- bias  in  ACC_W  signed bias; sampled on the first beat of a window.
- shift  in  5  right-shift amount 0..31; sampled in the RND state.
- relu_en  in  1  clamp negatives to 0; sampled in the RND state.
- out_data  out  OUT_W  signed requantized result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- err_len  out  1  sticky flag: a window hit MAX_TAPS without in_last.

Behaviour:
- Reset (async assert) values:
  - state=ACC, acc=0, beat_cnt=0, out_data=0, out_valid=0, err_len=0.
  - in_ready is 1 in the first cycle after reset deassertion.
- FSM states: ACC, RND, EMIT.
- ACC state:
  - in_ready=1, out_valid=0.
  - A beat is accepted on in_valid & in_ready.
  - First beat of a window (beat_cnt==0): acc <= sat(sext(bias) + sext(in_prod)).
  - Later beats: acc <= sat(acc + sext(in_prod)).
  - Each accepted beat increments beat_cnt.
  - If in_last=1, or this is beat number MAX_TAPS, go to RND.
  - If beat MAX_TAPS is reached with in_last=0, also set err_len=1. It stays set until reset.
- Accumulator saturation: compute at ACC_W+1 bits, then clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- RND state (one cycle): compute the result and register it into out_data.
  - r = acc + (shift>0 ? 2^(shift-1) : 0), computed at ACC_W+1 bits (round half up).
  - r = r >>> shift (arithmetic).
  - If relu_en and r<0, r = 0.
  - Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Next state EMIT, out_valid=1, in_ready=0.
- EMIT state:
  - out_data and out_valid are held stable until out_ready=1.
  - On handshake: out_valid=0, beat_cnt=0, next state ACC.
- Latency: last beat accepted in cycle T gives out_valid=1 in cycle T+2. With out_ready=1, in_ready returns in cycle T+3.
- No overlap between windows; in_ready=0 throughout RND and EMIT.
- in_last on a beat is ignored unless that beat is accepted.
- in_valid=0 in ACC: acc and beat_cnt are held; no timeout.
- Reset asserted mid-window or during EMIT: the partial window is discarded and all outputs return to reset values immediately.

Test Plan:
- Basic sum: bias=0, shift=0, relu_en=0, beats 100, -30, 5 (last) -> out_data=75, out_valid two cycles after the last beat.
- Rounding, single-beat windows with shift=4: prod 24 -> 2; prod -24 -> -1; prod 8 -> 1; prod 7 -> 0.
- Saturation:
  - 40 beats of 67108863 (2^26-1) with bias=0, shift=0 -> acc clamps at 2147483647, out_data=32767.
  - 40 beats of -67108864 -> out_data=-32768.
- ReLU and bias: bias=-1000, prod 500 (last), shift=0:
  - relu_en=1 -> 0.
  - relu_en=0 -> -500.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_data stable and in_ready=0 throughout. Raise out_ready -> next window's first beat accepted the cycle after the handshake.
- MAX_TAPS=4 and reset:
  - 5 beats of 1 without in_last -> result 4 emitted after the 4th beat, err_len=1, 5th beat waits and opens the next window.
  - Assert ap_rst mid-window -> err_len=0, out_valid=0, next window starts from bias.

Source files
------------

// File: rtl/lane_seg_mac_requant.sv
// lane_seg_mac_requant
// Accumulates one window of signed products onto a bias, then rounds
// (half up), arithmetic-shifts, optionally applies ReLU and saturates
// the result to a signed OUT_W activation. Valid/ready on both sides;
// windows never overlap (in_ready is low while a result is pending).
module lane_seg_mac_requant #(
    parameter int PROD_W   = 27,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 16,
    parameter int MAX_TAPS = 64
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_len
);

    localparam int CNT_W = $clog2(MAX_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TAPS - 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Output clamp bounds, sign-extended to the ACC_W+1 rounding width
    localparam logic signed [ACC_W:0] OUT_MAX_X = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN_X = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC,
        ST_RND,
        ST_EMIT
    } state_t;

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]         beat_cnt_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic signed [OUT_W-1:0]  res_d;
    logic                     out_valid_q;
    logic                     err_len_q;
    logic                     last_tap;

    logic signed [ACC_W-1:0]  acc_base;
    logic [ACC_W:0]           acc_sum;
    logic [ACC_W:0]           rnd_inc;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    rnd_sh;
    logic signed [ACC_W:0]    rnd_relu;

    assign in_ready  = (state_q == ST_ACC);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err_len   = err_len_q;
    assign last_tap  = (beat_cnt_q == LAST_IDX);

    // Next accumulator value: bias on the first beat, then running sum, saturated
    always_comb begin
        acc_base = (beat_cnt_q == '0) ? bias : acc_q;
        acc_sum  = {acc_base[ACC_W-1], acc_base}
                 + {{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod};
        if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
            acc_d = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_d = acc_sum[ACC_W-1:0];
        end
    end

    // Requantization: round half up at ACC_W+1 bits, shift, ReLU, clamp
    always_comb begin
        rnd_inc = '0;
        if (shift != '0) begin
            rnd_inc = {{ACC_W{1'b0}}, 1'b1} << (shift - 5'd1);
        end
        rnd_sum  = $signed({acc_q[ACC_W-1], acc_q}) + $signed(rnd_inc);
        rnd_sh   = rnd_sum >>> shift;
        rnd_relu = (relu_en && rnd_sh[ACC_W]) ? '0 : rnd_sh;
        if (rnd_relu > OUT_MAX_X) begin
            res_d = OUT_MAX_X[OUT_W-1:0];
        end else if (rnd_relu < OUT_MIN_X) begin
            res_d = OUT_MIN_X[OUT_W-1:0];
        end else begin
            res_d = rnd_relu[OUT_W-1:0];
        end
    end

    // Window FSM: accumulate beats, one rounding cycle, hold result until taken
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    out_valid_q <= 1'b0;
                    if (in_valid) begin
                        acc_q      <= acc_d;
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (in_last || last_tap) begin
                            state_q <= ST_RND;
                        end
                        if (!in_last && last_tap) begin
                            err_len_q <= 1'b1;
                        end
                    end
                end
                ST_RND: begin
                    out_data_q  <= res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        beat_cnt_q  <= '0;
                        state_q     <= ST_ACC;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_seg_mac_requant.sv
// Directed bench for lane_seg_mac_requant: a default instance (MAX_TAPS=64)
// and a MAX_TAPS=4 instance share all inputs; sel4 picks which is observed.
module tb_lane_seg_mac_requant;

    logic               clk;
    logic               ap_rst;
    logic signed [26:0] in_prod;
    logic               in_last;
    logic               in_valid;
    logic signed [31:0] bias;
    logic [4:0]         shift;
    logic               relu_en;
    logic               out_ready;

    logic               in_ready_m, out_valid_m, err_len_m;
    logic signed [15:0] out_data_m;
    logic               in_ready_4, out_valid_4, err_len_4;
    logic signed [15:0] out_data_4;

    logic               sel4;
    int                 errors;
    int                 checks;

    logic signed [26:0] rnd_p [4];
    int                 rnd_e [4];

    lane_seg_mac_requant dut (
        .ap_clk    (clk),
        .ap_rst    (ap_rst),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .bias      (bias),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_data  (out_data_m),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .err_len   (err_len_m)
    );

    lane_seg_mac_requant #(.MAX_TAPS(4)) dut4 (
        .ap_clk    (clk),
        .ap_rst    (ap_rst),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready_4),
        .bias      (bias),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_data  (out_data_4),
        .out_valid (out_valid_4),
        .out_ready (out_ready),
        .err_len   (err_len_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rdy();
        return sel4 ? in_ready_4 : in_ready_m;
    endfunction

    function automatic logic ov();
        return sel4 ? out_valid_4 : out_valid_m;
    endfunction

    function automatic logic signed [15:0] od();
        return sel4 ? out_data_4 : out_data_m;
    endfunction

    function automatic logic err();
        return sel4 ? err_len_4 : err_len_m;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat; returns #1 after the accepting edge (cycle T+1)
    task automatic beat(input logic signed [26:0] p, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_prod  = p;
        in_last  = l;
        in_valid = 1'b1;
        while (!rdy() && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("beat_accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last beat: RND cycle, then result in T+2
    task automatic expect_result(input string tag, input logic signed [15:0] exp);
        @(negedge clk);
        check({tag, "_rnd_valid"}, ov(), 0);
        check({tag, "_rnd_ready"}, rdy(), 0);
        @(negedge clk);
        check({tag, "_valid"}, ov(), 1);
        check({tag, "_data"}, od(), exp);
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        ap_rst   = 1'b1;
        @(negedge clk);
        ap_rst   = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        sel4      = 1'b0;
        ap_rst    = 1'b1;
        in_prod   = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        bias      = '0;
        shift     = '0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        rnd_p = '{27'sd24, -27'sd24, 27'sd8, 27'sd7};
        rnd_e = '{2, -1, 1, 0};

        // Reset values
        #12;
        check("rst_out_data", out_data_m, 0);
        check("rst_out_valid", out_valid_m, 0);
        check("rst_err_len", err_len_m, 0);
        @(negedge clk);
        ap_rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready_m, 1);
        check("rst_in_ready4", in_ready_4, 1);

        // Basic sum with idle gaps between beats
        beat(27'sd100, 1'b0);
        repeat (3) @(posedge clk);
        beat(-27'sd30, 1'b0);
        repeat (2) @(posedge clk);
        beat(27'sd5, 1'b1);
        expect_result("basic", 16'sd75);

        // Rounding, shift=4, single-beat windows
        shift = 5'd4;
        for (int i = 0; i < 4; i++) begin
            beat(rnd_p[i], 1'b1);
            expect_result($sformatf("round%0d", i), 16'(rnd_e[i]));
        end

        // Half-up on a negative half: (-3 + 1) >>> 1 = -1
        shift = 5'd1;
        beat(-27'sd3, 1'b1);
        expect_result("round_neg_half", -16'sd1);

        // Rounding needs the extra bit: 2^30+1 + 2^30 >>> 31 = 1
        bias  = 32'sh40000000;
        shift = 5'd31;
        beat(27'sd1, 1'b1);
        expect_result("round_wide", 16'sd1);

        // Positive and negative accumulator saturation
        bias  = '0;
        shift = '0;
        repeat (39) beat(27'sd67108863, 1'b0);
        beat(27'sd67108863, 1'b1);
        check("sat_acc_pos", dut.acc_q, 64'sd2147483647);
        expect_result("sat_pos", 16'sd32767);
        repeat (39) beat(-27'sd67108864, 1'b0);
        beat(-27'sd67108864, 1'b1);
        check("sat_acc_neg", dut.acc_q, -64'sd2147483648);
        expect_result("sat_neg", -16'sd32768);

        // ReLU and bias
        bias    = -32'sd1000;
        relu_en = 1'b1;
        beat(27'sd500, 1'b1);
        expect_result("relu_on", 16'sd0);
        relu_en = 1'b0;
        beat(27'sd500, 1'b1);
        expect_result("relu_off", -16'sd500);

        // Backpressure: result held, offered beat not taken until handshake
        bias      = '0;
        out_ready = 1'b0;
        beat(27'sd3, 1'b0);
        beat(27'sd4, 1'b1);
        expect_result("bp", 16'sd7);
        in_prod  = 27'sd9;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_valid%0d", i), ov(), 1);
            check($sformatf("bp_hold_data%0d", i), od(), 7);
            check($sformatf("bp_hold_ready%0d", i), rdy(), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hs_valid", ov(), 0);
        check("bp_hs_ready", rdy(), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("bp_next", 16'sd9);

        // Forced termination at MAX_TAPS=4
        pulse_reset();
        sel4 = 1'b1;
        bias = '0;
        repeat (4) beat(27'sd1, 1'b0);
        in_prod  = 27'sd1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        bias     = 32'sd10;
        @(negedge clk);
        check("taps_rnd_ready", rdy(), 0);
        check("taps_rnd_valid", ov(), 0);
        @(negedge clk);
        check("taps_valid", ov(), 1);
        check("taps_data", od(), 4);
        check("taps_err", err(), 1);
        check("taps_emit_ready", rdy(), 0);
        @(posedge clk);
        #1;
        check("taps_hs_ready", rdy(), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("taps_next", 16'sd11);
        check("taps_err_sticky", err(), 1);

        // Reset mid-window discards the partial sum and clears err_len
        bias = '0;
        beat(27'sd2, 1'b0);
        beat(27'sd2, 1'b0);
        #2;
        ap_rst = 1'b1;
        #1;
        check("midrst_err", err_len_4, 0);
        check("midrst_valid", out_valid_4, 0);
        check("midrst_data", out_data_4, 0);
        check("midrst_ready", in_ready_4, 1);
        @(negedge clk);
        ap_rst = 1'b0;
        bias   = 32'sd100;
        beat(27'sd5, 1'b1);
        expect_result("midrst_new", 16'sd105);

        // Reset during EMIT drops the pending result at once
        sel4      = 1'b0;
        pulse_reset();
        bias      = '0;
        out_ready = 1'b0;
        beat(27'sd7, 1'b1);
        expect_result("emitrst", 16'sd7);
        #2;
        ap_rst = 1'b1;
        #1;
        check("emitrst_valid", out_valid_m, 0);
        check("emitrst_data", out_data_m, 0);
        check("emitrst_ready", in_ready_m, 1);
        @(negedge clk);
        ap_rst    = 1'b0;
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
